cam_reg_sequencer: RTL and testbench

Camera register sequencer that drives the SCCB serial writer. It runs once after reset: power-up wait, OV7670 soft reset (COM7 = 0x80), settle wait, then a fixed register table. After that it accepts 16-bit exposure updates from the HDR control path and writes each one as three register writes (COM1, AECH, AECHH), so alternate frames can use different exposures. It drives the SCCB writer's `sccb_start`, `address` and `data` inputs and watches its `ready` output.

---
 rtl/cam_reg_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_cam_reg_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_reg_sequencer.sv
// Camera register sequencer for an OV7670 behind an SCCB serial writer.
// After reset it waits for power-up, soft-resets the sensor (COM7 = 0x80), waits for the
// sensor to settle, then writes a fixed register table. Once configured it accepts 16-bit
// exposure updates and writes each as COM1, AECH, AECHH so alternate frames can differ.
//
// Ports:
//   clk_25M_i        25 MHz system clock
//   rst_n_25M_i      asynchronous active-low reset
//   sccb_ready_i     SCCB writer idle flag
//   sccb_start_o     write request, level-held until the writer drops ready
//   sccb_address_o   camera register address
//   sccb_data_o      camera register data
//   exp_valid_i      exposure update request
//   exp_value_i      exposure value AEC[15:0]
//   exp_ready_o      exposure update can be accepted (IDLE only)
//   config_done_o    initial configuration complete, sticky until reset
module cam_reg_sequencer #(
  parameter int unsigned POWERUP_WAIT = 250000,
  parameter int unsigned RESET_WAIT   = 250000,
  parameter int unsigned ROM_DEPTH    = 64
) (
  input  logic        clk_25M_i,
  input  logic        rst_n_25M_i,
  input  logic        sccb_ready_i,
  output logic        sccb_start_o,
  output logic [7:0]  sccb_address_o,
  output logic [7:0]  sccb_data_o,
  input  logic        exp_valid_i,
  input  logic [15:0] exp_value_i,
  output logic        exp_ready_o,
  output logic        config_done_o
);

  localparam int unsigned IdxW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int unsigned MaxWait = (POWERUP_WAIT > RESET_WAIT) ? POWERUP_WAIT : RESET_WAIT;
  localparam int unsigned CntW    = ($clog2(MaxWait + 1) > 18) ? $clog2(MaxWait + 1) : 18;

  typedef enum logic [2:0] {
    StPwrWait,
    StLoad,
    StIssue,
    StAck,
    StBusy,
    StSettle,
    StIdle,
    StExpLoad
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rom_idx_q, rom_idx_d;
  logic              exp_mode_q, exp_mode_d;   // current write belongs to an exposure update
  logic [1:0]        exp_step_q, exp_step_d;
  logic [15:0]       exp_q, exp_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d;
  logic              config_done_q, config_done_d;

  logic [15:0]       rom_word;
  logic [7:0]        exp_addr;
  logic [7:0]        exp_data;

  // Register table: {addr, data}; addr 0xFF terminates.
  function automatic logic [15:0] rom_entry(input logic [IdxW-1:0] idx);
    case (idx)
      IdxW'(0): rom_entry = 16'h1280;  // COM7: soft reset
      IdxW'(1): rom_entry = 16'h1101;  // CLKRC: prescaler
      IdxW'(2): rom_entry = 16'h0C04;  // COM3: scaling enable
      IdxW'(3): rom_entry = 16'h3E19;  // COM14: PCLK divider
      default:  rom_entry = 16'hFFFF;
    endcase
  endfunction

  assign rom_word = rom_entry(rom_idx_q);

  always_comb begin
    exp_addr = 8'h07;
    exp_data = {2'b00, exp_q[15:10]};
    unique case (exp_step_q)
      2'd0: begin
        exp_addr = 8'h04;
        exp_data = {6'b0, exp_q[1:0]};
      end
      2'd1: begin
        exp_addr = 8'h10;
        exp_data = exp_q[9:2];
      end
      default: begin
        exp_addr = 8'h07;
        exp_data = {2'b00, exp_q[15:10]};
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rom_idx_d     = rom_idx_q;
    exp_mode_d    = exp_mode_q;
    exp_step_d    = exp_step_q;
    exp_d         = exp_q;
    addr_d        = addr_q;
    data_d        = data_q;
    start_d       = start_q;
    config_done_d = config_done_q;

    unique case (state_q)
      StPwrWait: begin
        if (cnt_q == CntW'(POWERUP_WAIT)) begin
          cnt_d     = '0;
          rom_idx_d = '0;
          state_d   = StLoad;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLoad: begin
        if (rom_word[15:8] == 8'hFF) begin
          config_done_d = 1'b1;
          state_d       = StIdle;
        end else begin
          addr_d     = rom_word[15:8];
          data_d     = rom_word[7:0];
          exp_mode_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (sccb_ready_i) begin
          start_d = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        // The writer acknowledges by dropping ready; no timeout by design.
        if (!sccb_ready_i) begin
          start_d = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (sccb_ready_i) begin
          if (exp_mode_q) begin
            if (exp_step_q == 2'd2) begin
              exp_step_d = 2'd0;
              state_d    = StIdle;
            end else begin
              exp_step_d = exp_step_q + 2'd1;
              state_d    = StExpLoad;
            end
          end else if (rom_idx_q == '0) begin
            cnt_d   = '0;
            state_d = StSettle;
          end else if (rom_idx_q == IdxW'(ROM_DEPTH - 1)) begin
            // Table filled every slot without an end marker.
            config_done_d = 1'b1;
            state_d       = StIdle;
          end else begin
            rom_idx_d = rom_idx_q + IdxW'(1);
            state_d   = StLoad;
          end
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(RESET_WAIT)) begin
          cnt_d     = '0;
          rom_idx_d = IdxW'(1);
          state_d   = StLoad;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (exp_valid_i) begin
          exp_d      = exp_value_i;
          exp_step_d = 2'd0;
          exp_mode_d = 1'b1;
          state_d    = StExpLoad;
        end
      end
      StExpLoad: begin
        addr_d  = exp_addr;
        data_d  = exp_data;
        state_d = StIssue;
      end
      default: state_d = StPwrWait;
    endcase
  end

  always_ff @(posedge clk_25M_i or negedge rst_n_25M_i) begin
    if (!rst_n_25M_i) begin
      state_q       <= StPwrWait;
      cnt_q         <= '0;
      rom_idx_q     <= '0;
      exp_mode_q    <= 1'b0;
      exp_step_q    <= 2'd0;
      exp_q         <= 16'h0000;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      start_q       <= 1'b0;
      config_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rom_idx_q     <= rom_idx_d;
      exp_mode_q    <= exp_mode_d;
      exp_step_q    <= exp_step_d;
      exp_q         <= exp_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      start_q       <= start_d;
      config_done_q <= config_done_d;
    end
  end

  assign sccb_start_o   = start_q;
  assign sccb_address_o = addr_q;
  assign sccb_data_o    = data_q;
  assign exp_ready_o    = (state_q == StIdle);
  assign config_done_o  = config_done_q;

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Bench for cam_reg_sequencer: behavioural SCCB writer that logs each write, an ordered
// queue of expected writes derived from the table and accepted exposure values, and a
// per-cycle check of exp_ready / config_done against that queue.
module tb_cam_reg_sequencer;

  localparam int unsigned PWait = 10;
  localparam int unsigned RWait = 20;
  localparam int unsigned LowCycles = 50;

  logic        clk;
  logic        rst_n;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_address;
  logic [7:0]  sccb_data;
  logic        exp_valid;
  logic [15:0] exp_value;
  logic        exp_ready;
  logic        config_done;

  cam_reg_sequencer #(
    .POWERUP_WAIT(PWait),
    .RESET_WAIT  (RWait),
    .ROM_DEPTH   (64)
  ) dut (
    .clk_25M_i     (clk),
    .rst_n_25M_i   (rst_n),
    .sccb_ready_i  (sccb_ready),
    .sccb_start_o  (sccb_start),
    .sccb_address_o(sccb_address),
    .sccb_data_o   (sccb_data),
    .exp_valid_i   (exp_valid),
    .exp_value_i   (exp_value),
    .exp_ready_o   (exp_ready),
    .config_done_o (config_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_wr[$];
  logic [15:0] hist[$];
  int  cyc = 0;
  int  rel_cyc = 0;
  int  fall_delay = 2;
  int  phase = 0;
  int  w = 0;
  int  low = 0;
  int  start_run = 0;
  int  start_hi_max = 0;
  int  com7_rise = 0;
  int  acc_cnt = 0;
  int  quiet_cnt = 0;
  int  tbl_left = 0;
  bit  first_pending = 0;
  bit  com7_pending = 0;
  bit  cfg_done_m = 0;
  logic [7:0] lat_addr;
  logic [7:0] lat_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Exposure split into COM1, AECH, AECHH writes.
  function automatic void push_exp(input logic [15:0] v);
    exp_wr.push_back({8'h04, 6'b0, v[1:0]});
    exp_wr.push_back({8'h10, v[9:2]});
    exp_wr.push_back({8'h07, 2'b0, v[15:10]});
  endfunction

  function automatic void push_table();
    exp_wr.push_back(16'h1280);
    exp_wr.push_back(16'h1101);
    exp_wr.push_back(16'h0C04);
    exp_wr.push_back(16'h3E19);
  endfunction

  // SCCB writer model: ready falls fall_delay cycles after start is seen, stays low 50.
  initial begin
    sccb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        sccb_ready = 1'b1;
        phase = 0;
        start_run = 0;
        com7_pending = 0;
        continue;
      end
      if (sccb_start) start_run++;
      else start_run = 0;
      if (start_run > start_hi_max) start_hi_max = start_run;
      case (phase)
        0: begin
          if (sccb_start && sccb_ready) begin
            lat_addr = sccb_address;
            lat_data = sccb_data;
            w = fall_delay;
            phase = 1;
            if (first_pending) begin
              check("first_start_latency_ok",
                    32'((cyc - rel_cyc >= int'(PWait) + 2) && (cyc - rel_cyc <= int'(PWait) + 4)),
                    32'd1);
              first_pending = 0;
            end
            if (com7_pending) begin
              check("settle_gap_ok", 32'(cyc - com7_rise >= int'(RWait)), 32'd1);
              com7_pending = 0;
            end
          end
        end
        1: begin
          check("addr_stable", 32'(sccb_address), 32'(lat_addr));
          check("data_stable", 32'(sccb_data), 32'(lat_data));
          check("start_held", 32'(sccb_start), 32'd1);
          w--;
          if (w <= 0) begin
            sccb_ready = 1'b0;
            hist.push_back({lat_addr, lat_data});
            if (exp_wr.size() == 0) begin
              check("write_extra", 32'({lat_addr, lat_data}), 32'hFFFF_FFFF);
            end else begin
              check("write_order", 32'({lat_addr, lat_data}), 32'(exp_wr.pop_front()));
              if (tbl_left > 0) begin
                tbl_left--;
                if (tbl_left == 0) cfg_done_m = 1;
              end
            end
            low = LowCycles;
            phase = 2;
          end
        end
        default: begin
          check("addr_stable_busy", 32'(sccb_address), 32'(lat_addr));
          check("data_stable_busy", 32'(sccb_data), 32'(lat_data));
          low--;
          if (low == 0) begin
            sccb_ready = 1'b1;
            phase = 0;
            if ({lat_addr, lat_data} == 16'h1280) begin
              com7_pending = 1;
              com7_rise = cyc;
            end
          end
        end
      endcase
    end
  end

  // Exposure acceptance: expected writes are queued from the accepted value.
  always @(posedge clk) begin
    if (rst_n && exp_valid && exp_ready) begin
      check("accept_only_when_idle", 32'(exp_wr.size() == 0 && cfg_done_m && phase == 0), 32'd1);
      push_exp(exp_value);
      acc_cnt++;
    end
  end

  // Per-cycle output checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_start", 32'(sccb_start), 32'd0);
      check("rst_addr", 32'(sccb_address), 32'd0);
      check("rst_data", 32'(sccb_data), 32'd0);
      check("rst_exp_ready", 32'(exp_ready), 32'd0);
      check("rst_config_done", 32'(config_done), 32'd0);
      quiet_cnt = 0;
    end else begin
      if (exp_wr.size() != 0) check("exp_ready_low_busy", 32'(exp_ready), 32'd0);
      if (!cfg_done_m) check("config_done_early", 32'(config_done), 32'd0);
      if (exp_wr.size() == 0 && phase == 0 && sccb_ready && !exp_valid) quiet_cnt++;
      else quiet_cnt = 0;
      if (cfg_done_m && quiet_cnt >= 4) begin
        check("exp_ready_idle", 32'(exp_ready), 32'd1);
        check("config_done_idle", 32'(config_done), 32'd1);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_start", 32'(sccb_start), 32'd0);
    check("async_rst_addr", 32'(sccb_address), 32'd0);
    check("async_rst_data", 32'(sccb_data), 32'd0);
    check("async_rst_exp_ready", 32'(exp_ready), 32'd0);
    check("async_rst_config_done", 32'(config_done), 32'd0);
    repeat (3) @(posedge clk);
    exp_wr.delete();
    push_table();
    tbl_left = 4;
    cfg_done_m = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rel_cyc = cyc;
    first_pending = 1;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(quiet_cnt >= 5 && cfg_done_m)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check({name, "_timeout"}, 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check({name, "_timeout"}, 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic send_exp(input logic [15:0] v, input int hold);
    @(negedge clk);
    exp_valid = 1'b1;
    exp_value = v;
    repeat (hold) @(negedge clk);
    exp_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    int n;
    rst_n = 1'b0;
    exp_valid = 1'b0;
    exp_value = 16'h0000;
    apply_reset();

    // Pulses during initialisation must be ignored.
    repeat (5) @(negedge clk);
    send_exp(16'h1234, 2);
    repeat (25) @(negedge clk);
    send_exp(16'h4321, 1);
    wait_quiet("init");
    check("init_write_count", 32'(hist.size()), 32'd4);
    if (hist.size() >= 4) begin
      check("init_first_com7", 32'(hist[0]), 32'h1280);
      check("init_last_entry", 32'(hist[3]), 32'h3E19);
    end
    check("init_config_done", 32'(config_done), 32'd1);
    check("init_exp_ready", 32'(exp_ready), 32'd1);

    // Single exposure, hand-computed split.
    base = hist.size();
    send_exp(16'hABCD, 1);
    wait_quiet("abcd");
    check("abcd_count", 32'(hist.size() - base), 32'd3);
    if (hist.size() >= base + 3) begin
      check("abcd_com1", 32'(hist[base]), 32'h0401);
      check("abcd_aech", 32'(hist[base+1]), 32'h10F3);
      check("abcd_aechh", 32'(hist[base+2]), 32'h072A);
    end
    check("abcd_exp_ready_back", 32'(exp_ready), 32'd1);

    // Pulse during an exposure sequence is dropped.
    base = hist.size();
    acc0 = acc_cnt;
    send_exp(16'h5A5A, 1);
    repeat (60) @(negedge clk);
    send_exp(16'h9999, 2);
    wait_quiet("busy_pulse");
    check("busy_pulse_accepts", 32'(acc_cnt - acc0), 32'd1);
    check("busy_pulse_count", 32'(hist.size() - base), 32'd3);

    // exp_valid held continuously across two updates.
    base = hist.size();
    acc0 = acc_cnt;
    @(negedge clk);
    exp_valid = 1'b1;
    exp_value = 16'h0003;
    wait_acc(acc0 + 1, "cont_first");
    exp_value = 16'hFFFF;
    wait_acc(acc0 + 2, "cont_second");
    exp_valid = 1'b0;
    wait_quiet("cont");
    check("cont_count", 32'(hist.size() - base), 32'd6);
    if (hist.size() >= base + 6) begin
      check("cont_0", 32'(hist[base]), 32'h0403);
      check("cont_1", 32'(hist[base+1]), 32'h1000);
      check("cont_2", 32'(hist[base+2]), 32'h0700);
      check("cont_3", 32'(hist[base+3]), 32'h0403);
      check("cont_4", 32'(hist[base+4]), 32'h10FF);
      check("cont_5", 32'(hist[base+5]), 32'h073F);
    end

    // Slow writer: start must be held until the late acknowledge.
    fall_delay = 30;
    start_hi_max = 0;
    base = hist.size();
    send_exp(16'($urandom), 1);
    wait_quiet("slow");
    check("slow_count", 32'(hist.size() - base), 32'd3);
    check("slow_start_held_30", 32'(start_hi_max >= 30), 32'd1);
    fall_delay = 2;

    // Randomised updates with occasional ignored pulses.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_exp(16'($urandom), $urandom_range(1, 3));
      if (i % 2 == 1) begin
        repeat ($urandom_range(10, 120)) @(negedge clk);
        send_exp(16'($urandom), 1);
      end
      wait_quiet("random");
    end

    // Reset while a write is being requested.
    fall_delay = 30;
    send_exp(16'h1357, 1);
    n = 0;
    while (phase != 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midwrite_reached", 32'(phase), 32'd1);
    repeat (5) @(negedge clk);
    base = hist.size();
    apply_reset();
    fall_delay = 2;
    wait_quiet("post_reset");
    check("post_reset_count", 32'(hist.size() - base), 32'd4);
    if (hist.size() > base) check("post_reset_com7", 32'(hist[base]), 32'h1280);
    check("post_reset_config_done", 32'(config_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
